// File: rtl/cdc_fifo_reader.sv
// Read side of a registered-output FIFO: a pre-set acknowledge plus a small
// circular buffer that absorbs the one-cycle skid between ack and data.
module cdc_fifo_reader #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [data_width-1:0]        fifo_read_data,
  input  logic                         fifo_read_valid,
  output logic                         fifo_read_ack,
  output logic [data_width-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic                         overflow
);

  localparam int unsigned   LW   = $clog2(depth + 1);
  localparam int unsigned   PW   = $clog2(depth);
  localparam logic [LW-1:0] FULL = LW'(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [data_width-1:0] r_mem [depth];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [LW-1:0]         r_level;
  logic                  r_ack_q;
  logic                  r_overflow;

  logic                  w_capture;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_store;
  logic [LW:0]           w_sum;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A word is new only if the FIFO advanced at the previous edge; otherwise it is a repeat.
  assign w_capture     = fifo_read_valid & r_ack_q;
  assign w_pop         = out_valid & out_ready;
  assign w_full        = (r_level == FULL);
  assign w_store       = w_capture & (~w_full | w_pop);
  // Ack reserves a slot for the word already in flight; one bit wider so depth+1 fits.
  assign w_sum         = {1'b0, r_level} + (LW+1)'(w_capture);
  assign fifo_read_ack = (w_sum < (LW+1)'(depth));

  assign out_valid = (r_level != '0);
  assign out_data  = r_mem[r_head];
  assign level     = r_level;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_q    <= 1'b0;
      r_level    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ack_q <= fifo_read_ack;
      if (w_store) r_tail <= wrap_inc(r_tail);
      if (w_pop)   r_head <= wrap_inc(r_head);
      if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_store && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_store)
        r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_tail] <= fifo_read_data;
  end

endmodule

// File: doc/cdc_fifo_reader.md
CDC_FIFO_READER -- requirements
Module: cdc_fifo_reader

Interface
REQ-001 SHALL have parameter: data_width, default 32, width of each data word.
REQ-002 SHALL have parameter: depth, default 4, number of output buffer entries; legal range 2..16.
REQ-003 SHALL have port: clk  input  1  single clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: fifo_read_data  input  data_width  FIFO read data, registered at the FIFO.
REQ-006 SHALL have port: fifo_read_valid  input  1  FIFO read data valid.
REQ-007 SHALL have port: fifo_read_ack  output  1  pre-set acknowledge, sampled by the FIFO at the same edge as valid.
REQ-008 SHALL have port: out_data  output  data_width  head word of the output buffer.
REQ-009 SHALL have port: out_valid  output  1  buffer non-empty.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the word when out_valid is high.
REQ-011 SHALL have port: level  output  $clog2(depth+1)  current buffer occupancy.
REQ-012 SHALL have port: overflow  output  1  sticky error flag.

Function
REQ-013 SHALL register ack_q, the value of fifo_read_ack at each edge.
REQ-014 SHALL define capture = fifo_read_valid && ack_q, meaning the FIFO advanced its pointer at the previous edge and the presented word is consumed.
REQ-015 SHALL write fifo_read_data into the tail entry at the edge where capture is high.
REQ-016 SHALL NOT store a word when fifo_read_valid is high and ack_q is low, because that word is repeated by the FIFO.
REQ-017 SHALL drive fifo_read_ack = (level + capture) < depth; it SHALL NOT depend combinationally on out_ready.
REQ-018 SHALL drive out_valid = (level != 0) and out_data = the head entry, both from registers with no input-to-output combinational path.
REQ-019 SHALL define pop = out_valid && out_ready; pop advances the head pointer.
REQ-020 SHALL update level at each edge: +1 on capture only, -1 on pop only, unchanged when both or neither occur.
REQ-021 SHALL make head and tail pointers wrap modulo depth; depth need not be a power of two.
REQ-022 SHALL keep word order identical to FIFO pop order, with no loss or duplication.
REQ-023 SHALL set overflow when capture occurs with level == depth and no simultaneous pop; the word is dropped, level stays at depth, and overflow is unreachable in legal use.
REQ-024 SHALL give latency from capture edge to out_valid of 1 cycle when the buffer is empty.
REQ-025 SHALL sustain one word per cycle when depth >= 3 and out_ready is held high; depth 2 MAY halve throughput.

Reset
REQ-026 SHALL, while reset_n is low, asynchronously clear: level=0, head=0, tail=0, ack_q=0, out_valid=0, overflow=0, fifo_read_ack=1.
REQ-027 SHALL leave buffer data storage unreset; out_data is don't-care while out_valid=0.
REQ-028 SHALL treat reset mid-operation as follows: buffered words are discarded; a word the FIFO presents on the first cycle after release is not captured (ack_q=0).

Structure
REQ-029 SHALL need no shared package; the level and pointer widths SHALL be local derived constants.
REQ-030 SHALL need no sub-module; the circular buffer, counters and flag SHALL be inline in cdc_fifo_reader.

Verification
REQ-031 SHALL pass this scenario: with the FIFO model holding words 0x11,0x22,0x33 and out_ready=1, out emits 0x11,0x22,0x33 on consecutive cycles, and fifo_read_ack stays 1 with depth=4.
REQ-032 SHALL pass this scenario: with out_ready=0 and a continuous supply, fifo_read_ack falls in the cycle where level+capture reaches 4; level settles at 4, and overflow stays 0.
REQ-033 SHALL pass this scenario: fifo_read_valid=1 with ack_q=0 (word 0xAA presented) results in no store and no level change; the same 0xAA is stored exactly once on the next acked cycle.
REQ-034 SHALL pass this scenario: capture and pop in the same cycle at level=4 leave level at 4, with no overflow and order preserved.
REQ-035 SHALL pass this scenario: forcing capture at level=4 with out_ready=0 sets overflow=1, which holds until reset.
REQ-036 SHALL pass this scenario: asserting reset_n=0 mid-stream at level=3 gives out_valid=0, level=0, fifo_read_ack=1 immediately, without waiting for a clock edge.
